// File: rtl/rc4_mem_pkg.sv
// Shared definitions for the RC4 working-RAM blocks (S-box init writer and read streamer).
package rc4_mem_pkg;

  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned MEM_AW    = 8;
  localparam int unsigned MEM_DW    = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitData,
    StPresent,
    StFinish
  } mem_rd_state_e;

endpackage

// File: rtl/fsm_mem_rd_stream.sv
// Sweeps the working RAM from START_ADDR to END_ADDR, streams each byte over valid/ready and
// optionally counts bytes that break the identity pattern (data == address).
module fsm_mem_rd_stream
  import rc4_mem_pkg::*;
#(
  parameter int unsigned        READ_LAT   = 1,
  parameter logic [MEM_AW-1:0]  START_ADDR = 8'h00,
  parameter logic [MEM_AW-1:0]  END_ADDR   = 8'hFF,
  parameter bit                 CHECK_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              finish,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_wr_en,
  input  logic [MEM_DW-1:0] mem_rd_data,
  output logic [MEM_DW-1:0] out_data,
  output logic [MEM_AW-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8:0]        err_count,
  output logic              err_seen,
  output logic [MEM_AW-1:0] first_err_addr
);

  if (START_ADDR > END_ADDR) begin : g_bad_range
    $error("fsm_mem_rd_stream: START_ADDR must not exceed END_ADDR");
  end
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
    $error("fsm_mem_rd_stream: READ_LAT must be 1..4");
  end

  localparam logic [1:0] LatLoad = 2'(READ_LAT - 1);

  mem_rd_state_e     state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [1:0]        lat_q, lat_d;
  logic [MEM_DW-1:0] data_q, data_d;
  logic [MEM_AW-1:0] oaddr_q, oaddr_d;
  logic              valid_q, valid_d;
  logic [8:0]        errc_q, errc_d;
  logic              errs_q, errs_d;
  logic [MEM_AW-1:0] ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    data_d  = data_q;
    oaddr_d = oaddr_q;
    valid_d = valid_q;
    errc_d  = errc_q;
    errs_d  = errs_q;
    ferr_d  = ferr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          addr_d  = START_ADDR;
          errc_d  = '0;
          errs_d  = 1'b0;
          ferr_d  = '0;
        end
      end
      StIssue: begin
        state_d = StWaitData;
        lat_d   = LatLoad;
      end
      StWaitData: begin
        if (lat_q == 2'd0) begin
          state_d = StPresent;
          data_d  = mem_rd_data;
          oaddr_d = addr_q;
          valid_d = 1'b1;
          if (CHECK_EN && (mem_rd_data != addr_q)) begin
            errc_d = errc_q + 9'd1;
            if (!errs_q) begin
              ferr_d = addr_q;
              errs_d = 1'b1;
            end
          end
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      StPresent: begin
        if (out_ready) begin
          valid_d = 1'b0;
          // Compare before incrementing so END_ADDR = 8'hFF never wraps.
          if (addr_q == END_ADDR) begin
            state_d = StFinish;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = StIssue;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= START_ADDR;
      lat_q   <= 2'd0;
      data_q  <= '0;
      oaddr_q <= '0;
      valid_q <= 1'b0;
      errc_q  <= '0;
      errs_q  <= 1'b0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      valid_q <= valid_d;
      errc_q  <= errc_d;
      errs_q  <= errs_d;
      ferr_q  <= ferr_d;
    end
  end

  assign finish         = (state_q == StFinish);
  assign mem_addr       = addr_q;
  assign mem_wr_en      = 1'b0;
  assign out_data       = data_q;
  assign out_addr       = oaddr_q;
  assign out_valid      = valid_q;
  assign err_count      = errc_q;
  assign err_seen       = errs_q;
  assign first_err_addr = ferr_q;

endmodule
